// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// The FIFO connects through the slave modport and the driver through the master modport.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic [DATA_W-1:0] pop_data;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;
  logic              err_clr;

  modport slave (
    input  push, push_data, pop, err_clr,
    output pop_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport master (
    output push, push_data, pop, err_clr,
    input  pop_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock show-ahead FIFO with registered occupancy flags.
// Sticky overflow/underflow flags exist only when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_param_if.slave   fif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              wr_en, rd_en;

  // Full/empty gate the requests, so simultaneous push+pop at the extremes
  // naturally degenerates to the single legal operation.
  always_comb begin
    wr_en    = fif.push && !full_q;
    rd_en    = fif.pop  && !empty_q;
    wptr_d   = wr_en ? wptr_q + AW'(1) : wptr_q;
    rptr_d   = rd_en ? rptr_q + AW'(1) : rptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CW'(AF_LEVEL));
    aempty_d = (count_d <= CW'(AE_LEVEL));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= fif.push_data;
  end

  assign fif.pop_data     = mem_q[rptr_q];
  assign fif.count        = count_q;
  assign fif.full         = full_q;
  assign fif.empty        = empty_q;
  assign fif.almost_full  = afull_q;
  assign fif.almost_empty = aempty_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (fif.push && full_q && !fif.pop) ovf_q <= 1'b1;
      else if (fif.err_clr)               ovf_q <= 1'b0;
      if (fif.pop && empty_q && !fif.push) udf_q <= 1'b1;
      else if (fif.err_clr)                udf_q <= 1'b0;
    end
  end

  assign fif.overflow  = ovf_q;
  assign fif.underflow = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = fif.err_clr;
  assign fif.overflow   = 1'b0;
  assign fif.underflow  = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param at default parameters.
module tb_sync_fifo_param;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   errs    = 0;
  logic [7:0] q [$];

  sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) fif ();

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input int n);
    chk({tag, " count"},  32'(fif.count), 32'(n));
    chk({tag, " full"},   32'(fif.full), 32'(n == 16));
    chk({tag, " empty"},  32'(fif.empty), 32'(n == 0));
    chk({tag, " afull"},  32'(fif.almost_full), 32'(n >= 14));
    chk({tag, " aempty"}, 32'(fif.almost_empty), 32'(n <= 2));
  endtask

  initial begin
    fif.push = 1'b0; fif.pop = 1'b0; fif.push_data = '0; fif.err_clr = 1'b0;

    // Reset state
    #12;
    chk_flags("reset", 0);
    chk("reset ovf", 32'(fif.overflow), 32'd0);
    chk("reset udf", 32'(fif.underflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      fif.push = 1'b1; fif.push_data = 8'(i);
      tick();
      chk_flags("fill", i);
      chk("fill head", 32'(fif.pop_data), 32'h01);
    end
    fif.push = 1'b0;

    // Drain, checking show-ahead order
    for (int i = 1; i <= 16; i++) begin
      chk("drain data", 32'(fif.pop_data), 32'(i));
      fif.pop = 1'b1;
      tick();
      chk_flags("drain", 16 - i);
    end
    fif.pop = 1'b0;

    // Push+pop while empty
    fif.push = 1'b1; fif.pop = 1'b1; fif.push_data = 8'hA5;
    tick();
    fif.push = 1'b0; fif.pop = 1'b0;
    chk_flags("pp empty", 1);
    chk("pp empty data", 32'(fif.pop_data), 32'hA5);
    chk("pp empty udf", 32'(fif.underflow), 32'd0);
    fif.pop = 1'b1;
    tick();
    fif.pop = 1'b0;
    chk_flags("pp empty drain", 0);

    // Fill with 0x20..0x2F, then push+pop while full
    for (int i = 0; i < 16; i++) begin
      fif.push = 1'b1; fif.push_data = 8'(8'h20 + i);
      tick();
    end
    chk_flags("refill", 16);
    fif.pop = 1'b1; fif.push_data = 8'hEE;
    tick();
    fif.pop = 1'b0;
    chk_flags("pp full", 15);
    chk("pp full ovf", 32'(fif.overflow), 32'd0);
    chk("pp full head", 32'(fif.pop_data), 32'h21);
    fif.push_data = 8'h30;
    tick();
    chk_flags("top up", 16);
    fif.push_data = 8'h77;
    tick();
    fif.push = 1'b0;
    chk_flags("push full", 16);
    chk("push full ovf", 32'(fif.overflow), 32'(ERR_EN));
    chk("push full head", 32'(fif.pop_data), 32'h21);
    fif.err_clr = 1'b1;
    tick();
    fif.err_clr = 1'b0;
    chk("ovf clr", 32'(fif.overflow), 32'd0);

    // Drain 0x21..0x30 (0x77 must have been discarded)
    for (int i = 0; i < 16; i++) begin
      chk("drain2 data", 32'(fif.pop_data), 32'(8'h21 + i));
      fif.pop = 1'b1;
      tick();
    end
    chk_flags("drain2", 0);

    // Pop on empty; set beats a simultaneous clear
    tick();
    chk("udf set", 32'(fif.underflow), 32'(ERR_EN));
    chk_flags("udf count", 0);
    fif.err_clr = 1'b1;
    tick();
    chk("udf set wins", 32'(fif.underflow), 32'(ERR_EN));
    fif.pop = 1'b0;
    tick();
    fif.err_clr = 1'b0;
    chk("udf clr", 32'(fif.underflow), 32'd0);

    // Interleaved traffic across pointer wrap against a queue model
    for (int i = 0; i < 40; i++) begin
      automatic bit  p = (i % 5) != 4;
      automatic bit  r = (i % 3) != 0;
      automatic logic [7:0] d = 8'(i * 7 + 3);
      automatic bit  acc_w = p && (q.size() < 16);
      automatic bit  acc_r = r && (q.size() > 0);
      if (q.size() > 0) chk("mix data", 32'(fif.pop_data), 32'(q[0]));
      fif.push = p; fif.pop = r; fif.push_data = d;
      tick();
      if (acc_r) void'(q.pop_front());
      if (acc_w) q.push_back(d);
      chk("mix count", 32'(fif.count), 32'(q.size()));
    end
    fif.push = 1'b0; fif.pop = 1'b0;

    // Asynchronous reset mid-burst at count 7
    @(negedge clk); rst = 1'b0; #1; rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      fif.push = 1'b1; fif.push_data = 8'(8'h50 + i);
      tick();
    end
    chk_flags("burst", 7);
    #2;
    rst = 1'b0;
    #1;
    chk_flags("async rst", 0);
    chk("async rst ovf", 32'(fif.overflow), 32'd0);
    chk("async rst udf", 32'(fif.underflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    fif.push_data = 8'h99;
    tick();
    fif.push = 1'b0;
    chk_flags("resume", 1);
    chk("resume data", 32'(fif.pop_data), 32'h99);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 SHALL provide parameter DEPTH, default 16, number of entries; power of two, >=4.
REQ-003 SHALL provide parameter AF_LEVEL, default 14, almost_full threshold in entries (1..DEPTH-1).
REQ-004 SHALL provide parameter AE_LEVEL, default 2, almost_empty threshold in entries (1..DEPTH-1).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port push  input  1  write request.
REQ-008 SHALL have port push_data  input  DATA_W  write data.
REQ-009 SHALL have port pop  input  1  read request.
REQ-010 SHALL have port pop_data  output  DATA_W  head-of-queue data, show-ahead.
REQ-011 SHALL have port full  output  1  count == DEPTH.
REQ-012 SHALL have port empty  output  1  count == 0.
REQ-013 SHALL have port almost_full  output  1  count >= AF_LEVEL.
REQ-014 SHALL have port almost_empty  output  1  count <= AE_LEVEL.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 SHALL have port overflow  output  1  sticky: push rejected because full.
REQ-017 SHALL have port underflow  output  1  sticky: pop rejected because empty.
REQ-018 SHALL have port err_clr  input  1  synchronous clear of overflow/underflow.

Function
REQ-019 SHALL store entries in a DEPTH x DATA_W array addressed by $clog2(DEPTH)-bit write/read pointers that wrap from DEPTH-1 to 0.
REQ-020 SHALL accept a write (store push_data at wptr, wptr+1) when push=1 and full=0.
REQ-021 SHALL accept a read (rptr+1) when pop=1 and empty=0.
REQ-022 SHALL, on push=pop=1 with 0<count<DEPTH, accept both; count unchanged.
REQ-023 SHALL, on push=pop=1 while empty, accept only the write; count 0->1.
REQ-024 SHALL, on push=pop=1 while full, accept only the read; count DEPTH->DEPTH-1; push_data discarded.
REQ-025 SHALL drive pop_data combinationally from array[rptr]; valid whenever empty=0, don't-care when empty=1.
REQ-026 SHALL make written data visible on pop_data one cycle after the accepted write (zero-to-one transition of empty).
REQ-027 SHALL register count, full, empty, almost_full, almost_empty, all updated on the same edge from next-state occupancy.
REQ-028 SHALL never let count exceed DEPTH or go below 0; rejected requests change no pointer or count.

Reset
REQ-029 SHALL, on rst=0, immediately clear wptr, rptr, count to 0; empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-030 SHALL discard in-flight requests on reset mid-operation; array contents not cleared; pop_data don't-care until next write.
REQ-031 SHALL resume normal operation on the first rising clk edge after rst returns to 1.

Configuration
REQ-032 SHALL compile overflow/underflow logic only when macro SYNC_FIFO_ERR_FLAGS_EN is defined.
REQ-033 SHALL, with SYNC_FIFO_ERR_FLAGS_EN: set overflow on push=1 while full=0 is false (full=1, pop=0); set underflow on pop=1 while empty=1 and push=0; clear both on err_clr=1; set wins over err_clr in the same cycle.
REQ-034 SHALL, without SYNC_FIFO_ERR_FLAGS_EN: keep identical port list, tie overflow=0 and underflow=0, ignore err_clr.

Verification (defaults DATA_W=8, DEPTH=16, AF=14, AE=2)
REQ-035 SHALL cover: reset, push 0x01..0x10 -> full=1 after 16th edge, count=16, almost_full=1 from count 14, pop_data=0x01.
REQ-036 SHALL cover: from full, pop 16 times -> pop_data sequence 0x01..0x10, empty=1 after 16th edge, almost_empty=1 from count 2.
REQ-037 SHALL cover: push+pop same cycle while empty with push_data=0xA5 -> count=1, pop_data=0xA5, no underflow.
REQ-038 SHALL cover: push+pop same cycle while full -> count=15, overflow stays 0; push alone while full -> overflow=1 (macro on), count=16, data unchanged.
REQ-039 SHALL cover: 40 writes/reads interleaved across pointer wrap -> data order preserved, count matches model every cycle.
REQ-040 SHALL cover: rst=0 asserted mid-burst at count=7 -> count=0, empty=1, flags cleared without a clock edge.
